// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are latched on grant, the result is captured one cycle later and returned with a done pulse.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [OPW-1:0]   op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res_out,
  output logic             zero_out,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e state;
  logic   last;   // requester granted most recently
  logic   owner;  // requester whose operation is in flight
  logic   grant_any;
  logic   winner;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_any = (state == StIdle) && (req0 || req1);
    winner    = (req0 && req1) ? ~last : req1;
  end

  assign gnt0 = grant_any & ~winner;
  assign gnt1 = grant_any & winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      last     <= 1'b1;
      owner    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      res_out  <= '0;
      zero_out <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        StIdle: begin
          if (grant_any) begin
            alu_a  <= winner ? a1 : a0;
            alu_b  <= winner ? b1 : b0;
            alu_op <= winner ? op1 : op0;
            owner  <= winner;
            last   <= winner;
            busy   <= 1'b1;
            state  <= StExec;
          end
        end
        StExec: begin
          res_out  <= alu_res;
          zero_out <= alu_zero;
          done0    <= ~owner;
          done1    <= owner;
          state    <= StDone;
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on the alu_* side.
// Expected results are queued at grant time and popped when a done pulse appears.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [OPW-1:0]   op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, done0, done1, zero_out, busy;
  logic [WIDTH-1:0] res_out, alu_a, alu_b, alu_res;
  logic [OPW-1:0]   alu_op;
  logic             alu_zero;

  typedef struct packed {
    logic             who;
    logic [WIDTH-1:0] res;
    logic             zero;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .op0      (op0),
    .a0       (a0),
    .b0       (b0),
    .req1     (req1),
    .op1      (op1),
    .a1       (a1),
    .b1       (b1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .res_out  (res_out),
    .zero_out (zero_out),
    .busy     (busy),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .alu_zero (alu_zero)
  );

  // Behavioural stand-in for the external ALU.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b000: alu_res = alu_a & alu_b;
      3'b001: alu_res = alu_a | alu_b;
      3'b010: alu_res = alu_a + alu_b;
      3'b011: alu_res = alu_a ^ alu_b;
      3'b100: alu_res = ~(alu_a | alu_b);
      3'b101: alu_res = alu_a >> 1;
      3'b110: alu_res = alu_a - alu_b;
      3'b111: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input logic req, input logic [OPW-1:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (!r) begin
      req0 = req; op0 = op; a0 = a; b0 = b;
    end else begin
      req1 = req; op1 = op; a1 = a; b1 = b;
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic issue(input bit r, input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er, input logic ez);
    bit seen;
    seen = 1'b0;
    drive(r, 1'b1, op, a, b);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (r ? gnt1 : gnt0) begin
        seen = 1'b1;
        break;
      end
    end
    check("gnt_seen", {31'b0, seen}, 32'd1);
    check("gnt_other", {31'b0, r ? gnt0 : gnt1}, 32'd0);
    if (seen) sb.push_back('{who: r, res: er, zero: ez});
    @(posedge clk); #1;
    drive(r, 1'b0, op, a, b);
    @(negedge clk);
    check("busy_exec", {31'b0, busy}, 32'd1);
    check("gnt_in_exec", {31'b0, gnt0 | gnt1}, 32'd0);
    @(negedge clk);
    check("done_latency", {31'b0, r ? done1 : done0}, 32'd1);
    check("done_other", {31'b0, r ? done0 : done1}, 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_excl", {31'b0, gnt0 & gnt1}, 32'd0);
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          check("done_unexpected", {30'b0, done1, done0}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("done_excl", {31'b0, done0 & done1}, 32'd0);
          check("done_owner", {31'b0, done1}, {31'b0, mon_e.who});
          check("res_out", res_out, mon_e.res);
          check("zero_out", {31'b0, zero_out}, {31'b0, mon_e.zero});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] sweep_res [8];
  int          grants[$];

  initial begin
    sweep_res = '{32'h2, 32'hB, 32'hD, 32'h9, 32'hFFFF_FFF4, 32'h5, 32'h7, 32'h0};
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);

    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_busy", {31'b0, busy}, 32'd0);
      check("idle_pulses", {28'b0, gnt0, gnt1, done0, done1}, 32'd0);
    end
    check("rst_res_out", res_out, 32'd0);
    check("rst_alu_op", {29'b0, alu_op}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    @(posedge clk); #1;

    // Single add
    issue(1'b0, 3'b010, 32'd5, 32'd7, 32'd12, 1'b0);

    // Simultaneous requests after reset
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 1'b1, 3'b110, 32'd9, 32'd9);
    drive(1'b1, 1'b1, 3'b001, 32'hF0, 32'h0F);
    @(negedge clk);
    check("tie_gnt0", {30'b0, gnt0, gnt1}, 32'd2);
    sb.push_back('{who: 1'b0, res: 32'd0, zero: 1'b1});
    @(posedge clk); #1 drive(1'b0, 1'b0, 3'b110, 32'd9, 32'd9);
    @(negedge clk);
    check("tie_exec_nognt", {30'b0, gnt0, gnt1}, 32'd0);
    @(negedge clk);
    check("tie_done0", {31'b0, done0}, 32'd1);
    @(negedge clk);
    check("tie_gnt1", {30'b0, gnt0, gnt1}, 32'd1);
    sb.push_back('{who: 1'b1, res: 32'hFF, zero: 1'b0});
    @(posedge clk); #1 drive(1'b1, 1'b0, 3'b001, 32'hF0, 32'h0F);
    @(negedge clk);
    @(negedge clk);
    check("tie_done1", {31'b0, done1}, 32'd1);
    @(posedge clk); #1;

    // Continuous contention: last grant was 1, so 0 leads
    drive(1'b0, 1'b1, 3'b010, 32'd1, 32'd2);
    drive(1'b1, 1'b1, 3'b011, 32'd5, 32'd5);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("cont_slot", {31'b0, gnt0 | gnt1}, (k % 3 == 0) ? 32'd1 : 32'd0);
      if (gnt0) begin
        grants.push_back(0);
        sb.push_back('{who: 1'b0, res: 32'd3, zero: 1'b0});
      end
      if (gnt1) begin
        grants.push_back(1);
        sb.push_back('{who: 1'b1, res: 32'd0, zero: 1'b1});
      end
    end
    check("cont_count", grants.size(), 32'd4);
    foreach (grants[i]) check("cont_order", grants[i], i % 2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);

    // Opcode sweep through requester 1
    for (int op = 0; op < 8; op++) begin
      issue(1'b1, op[2:0], 32'hA, 32'h3, sweep_res[op], (sweep_res[op] == 0));
    end

    // Reset during EXEC aborts the operation
    issue(1'b0, 3'b010, 32'd3, 32'd4, 32'd7, 1'b0);
    drive(1'b0, 1'b1, 3'b010, 32'd1, 32'd1);
    @(negedge clk);
    check("abort_gnt0", {31'b0, gnt0}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b010, 32'd1, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_res_out", res_out, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {30'b0, done0, done1}, 32'd0);
    check("abort_alu_a", alu_a, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b010, 32'd2, 32'd2);
    drive(1'b1, 1'b1, 3'b000, 32'hF, 32'hF);
    @(negedge clk);
    check("post_rst_tie", {30'b0, gnt0, gnt1}, 32'd2);
    if (gnt0) sb.push_back('{who: 1'b0, res: 32'd4, zero: 1'b0});
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_done0", {31'b0, done0}, 32'd1);
    @(posedge clk); #1;
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters.
  - Requester 0 is the datapath issue port; requester 1 is the auxiliary/debug port.
- Performs round-robin arbitration and latches the winner's operands and opcode.
- Drives the ALU from registers, captures res/zero, and returns the result with a one-cycle done pulse to the granted requester.
- Sits between the requesters and the existing alu module; that module is instantiated outside this block.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OPW, 3, opcode width; must match the ALU_operation encoding.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 has an operation pending; held until gnt0.
- op0  input  OPW  requester 0 opcode.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1, op1, a1, b1  input  1/OPW/WIDTH/WIDTH  requester 1; same meaning as requester 0.
- gnt0  output  1  one-cycle pulse: requester 0's operands were latched this cycle.
- gnt1  output  1  one-cycle pulse: requester 1's operands were latched this cycle.
- done0  output  1  one-cycle pulse: res_out/zero_out valid for requester 0.
- done1  output  1  one-cycle pulse: res_out/zero_out valid for requester 1.
- res_out  output  WIDTH  registered ALU result of the last completed operation.
- zero_out  output  1  registered ALU zero flag of the last completed operation.
- busy  output  1  high while state != IDLE.
- alu_a  output  WIDTH  to ALU A; driven from the latched operand register.
- alu_b  output  WIDTH  to ALU B; driven from the latched operand register.
- alu_op  output  OPW  to ALU_operation; driven from the latched opcode register.
- alu_res  input  WIDTH  from ALU res.
- alu_zero  input  1  from ALU zero.

Behaviour:
- Opcode encoding (pass-through, no decode here): 000 and, 001 or, 010 add, 011 xor, 100 nor, 101 srl-by-1 of A, 110 sub, 111 slt (unsigned).
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - gnt0, gnt1, done0, done1, busy = 0.
  - res_out = 0, zero_out = 0.
  - alu_a = 0, alu_b = 0, alu_op = 3'b000.
  - last-grant pointer = 1, so requester 0 wins the first tie.
  - owner = 0.
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - No req: stay in IDLE; all pulses 0.
  - Exactly one req: grant that requester.
  - Both req: grant the requester != last-grant pointer.
  - On grant:
    - latch op/a/b of the winner into alu_op/alu_a/alu_b;
    - owner <= winner; pointer <= winner;
    - gnt of the winner = 1 in the same cycle the request is sampled (Mealy: combinational from state/req/pointer; registered latch at the edge);
    - next state EXEC.
- EXEC: ALU settles from the registered inputs. At the edge, res_out <= alu_res, zero_out <= alu_zero; next state DONE.
- DONE: done of owner = 1 for exactly this cycle; next state IDLE. res_out/zero_out hold until the next EXEC capture.
- Latency and throughput:
  - Grant to done is 2 cycles.
  - One operation per 3 cycles.
  - A req held continuously through DONE is re-arbitrated in IDLE. No grant is issued in EXEC or DONE.
- Handshake:
  - Requester holds req/op/a/b stable until it sees gnt; it may change them the cycle after gnt.
  - A req still high after gnt is treated as a new request.
  - Request inputs are don't-care outside the IDLE sampling cycle.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1...; neither starves for more than one operation.
- Reset mid-operation (EXEC or DONE): operation is aborted, no done pulse, outputs go to their reset values the next cycle.
- gnt0 & gnt1 never both 1; done0 & done1 never both 1.
- The ALU overflow output is not consumed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then no req for 5 cycles -> busy=0, no gnt/done pulses, res_out=0, alu_op=000.
- Single add: req0, op0=010, a0=5, b0=7 -> gnt0 at cycle T, done0 at T+2, res_out=12, zero_out=0, done1 never asserted.
- Simultaneous requests after reset: req0 sub 9-9, req1 or 0xF0|0x0F, both held after first gnt -> gnt0 first, done0 with res_out=0/zero_out=1; then gnt1 in the following IDLE cycle, done1 with res_out=0xFF.
- Continuous contention: both req held high for 12 cycles -> grants alternate 0,1,0,1 at 3-cycle spacing, 4 operations total.
- Opcode sweep via requester 1: a1=0xA, b1=0x3, all 8 ops -> and 0x2, or 0xB, add 0xD, xor 0x9, nor 0xFFFFFFF4, srl 0x5, sub 0x7, slt 0.
- Reset mid-op: rst=1 during EXEC of an add 1+1 -> no done0, res_out=0, state IDLE; the next request is granted to requester 0 on a tie.
